// File: rtl/rr_sel_sequencer.sv
// Round-robin sequencer driving a 2-to-4 select decoder: one grant at a time, bounded dwell,
// one-cycle dead gap between grants. All outputs registered; grant appears 1 cycle after request.
module rr_sel_sequencer #(
  parameter int DWELL = 8,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic       en,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [1:0]         ptr_q, ptr_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [1:0]         win;
  logic [1:0]         idx;
  logic               found;
  logic               expire;

  // Circular search starting just after the last-served channel, so it ends up lowest priority.
  always_comb begin
    win   = ptr_q;
    idx   = ptr_q;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign expire = (cnt_q == CNT_W'(DWELL - 1));

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    en_d      = en_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE, GAP: begin
        if (found) begin
          state_d = GRANT;
          sel_d   = win;
          ptr_d   = win;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end
      end
      GRANT: begin
        if (done || !req[sel_q] || expire) begin
          state_d   = GAP;
          en_d      = 1'b0;
          cnt_d     = '0;
          // done and withdrawal both take precedence over expiry
          timeout_d = !done && req[sel_q];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= 2'd0;
      ptr_q     <= 2'd3;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign sel     = sel_q;
  assign en      = en_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule
